pipe_stage_fifo: RTL and testbench

// - Parametrised inter-stage buffer for the 5-stage core (IF/ID/EX/MEM/WB links).
// - Replaces the single-entry valid/ack register each stage builds by hand.
// - Adds configurable width and depth, an occupancy count, flush and halt handling.
// - Optional same-cycle bypass when empty.
//

---
 rtl/pipe_stage_fifo.sv | 109 ++++++++++
 tb/tb_pipe_stage_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Parametrised valid/ack inter-stage buffer with occupancy count, flush and halt.
// Define PIPE_STAGE_FIFO_BYPASS_EN for a zero-latency pass-through while empty.
module pipe_stage_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             halt_i,
    input  logic             valid_i,
    output logic             ack_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic open;
    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    assign open  = ~halt_i & ~flush_i;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // ack_o is independent of ack_i: no combinational path from downstream to upstream.
    assign ack_o = ~full & open;

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
    assign bypass = empty & open;
`else
    assign bypass = 1'b0;
`endif

    assign valid_o = bypass ? valid_i : (~empty & open);
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign push = valid_i & ack_o;
    assign pop  = valid_o & ack_i;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign wr_en = push & ~(bypass & ack_i);
    assign rd_en = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared only by reset; flush just rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=3 instance share reset,
// flush and halt; each scenario task checks its own instance against a queue model.
module tb_pipe_stage_fifo;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic flush = 1'b0;
    logic halt = 1'b0;

    logic         v2 = 1'b0, a2 = 1'b0, ack2, valid2;
    logic [W-1:0] d2 = '0, dout2;
    logic [1:0]   count2;

    logic         v3 = 1'b0, a3 = 1'b0, ack3, valid3;
    logic [W-1:0] d3 = '0, dout3;
    logic [1:0]   count3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] sb2[$];
    logic [W-1:0] sb3[$];

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(2)) dut2 (
        .clk(clk), .rst_i(rst), .flush_i(flush), .halt_i(halt),
        .valid_i(v2), .ack_o(ack2), .data_i(d2),
        .valid_o(valid2), .ack_i(a2), .data_o(dout2), .count_o(count2)
    );

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(3)) dut3 (
        .clk(clk), .rst_i(rst), .flush_i(flush), .halt_i(halt),
        .valid_i(v3), .ack_o(ack3), .data_i(d3),
        .valid_o(valid3), .ack_i(a3), .data_o(dout3), .count_o(count3)
    );

    function automatic logic m_ack(int sz, int depth);
        return (sz != depth) && !halt && !flush;
    endfunction

    function automatic logic m_valid(int sz, logic vin);
        logic v;
        v = (sz != 0) && !halt && !flush;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        if (sz == 0 && !halt && !flush) v = vin;
`endif
        return v;
    endfunction

    task automatic commit2(input logic ev, input logic ea);
        logic passed;
        if (rst || flush) begin
            sb2.delete();
        end else begin
            passed = ev && a2 && (sb2.size() == 0);
            if (ev && a2 && sb2.size() != 0) void'(sb2.pop_front());
            if (v2 && ea && !passed) sb2.push_back(d2);
        end
    endtask

    task automatic commit3(input logic ev, input logic ea);
        logic passed;
        if (rst || flush) begin
            sb3.delete();
        end else begin
            passed = ev && a3 && (sb3.size() == 0);
            if (ev && a3 && sb3.size() != 0) void'(sb3.pop_front());
            if (v3 && ea && !passed) sb3.push_back(d3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ack2 !== 1'b1) begin
            n_fail++; $display("FAIL reset_ack_held: got %b, want 1", ack2);
        end
        n_checks++;
        if (valid2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_held: got %b, want 0", valid2);
        end
        rst = 1'b0;
        sb2.delete();
        sb3.delete();
        @(negedge clk);
        n_checks++;
        if (valid2 !== 1'b0 || count2 !== 2'd0) begin
            n_fail++; $display("FAIL reset_dut2: valid %b count %0d, want 0 0", valid2, count2);
        end
        n_checks++;
        if (dout2 !== '0 || ack2 !== 1'b1) begin
            n_fail++; $display("FAIL reset_dut2_data: data %h ack %b, want 0 1", dout2, ack2);
        end
        n_checks++;
        if (valid3 !== 1'b0 || count3 !== 2'd0 || dout3 !== '0 || ack3 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dut3: valid %b count %0d data %h ack %b, want 0 0 0 1",
                     valid3, count3, dout3, ack3);
        end
    endtask

    // Scenario step table for DEPTH=2: {flush, halt, valid, ack, data}
    task automatic run2(input string name, input logic [W+3:0] steps[$]);
        logic ev, ea;
        logic [W-1:0] ed;
        for (int c = 0; c < steps.size(); c++) begin
            @(negedge clk);
            {flush, halt, v2, a2, d2} = steps[c];
            #1;
            ea = m_ack(sb2.size(), 2);
            ev = m_valid(sb2.size(), v2);
            ed = (sb2.size() != 0) ? sb2[0] : d2;
            n_checks++;
            if (ack2 !== ea) begin
                n_fail++; $display("FAIL %s_ack cyc %0d: got %b, want %b", name, c, ack2, ea);
            end
            n_checks++;
            if (valid2 !== ev) begin
                n_fail++; $display("FAIL %s_valid cyc %0d: got %b, want %b", name, c, valid2, ev);
            end
            n_checks++;
            if (count2 !== 2'(sb2.size())) begin
                n_fail++;
                $display("FAIL %s_count cyc %0d: got %0d, want %0d", name, c, count2, sb2.size());
            end
            if (ev) begin
                n_checks++;
                if (dout2 !== ed) begin
                    n_fail++; $display("FAIL %s_data cyc %0d: got %h, want %h", name, c, dout2, ed);
                end
            end
            @(posedge clk);
            commit2(ev, ea);
        end
        @(negedge clk);
        {flush, halt, v2, a2, d2} = '0;
    endtask

    task automatic test_fill_drain();
        logic [W+3:0] s[$];
        s = '{{4'b0010, 16'h000A}, {4'b0010, 16'h000B}, {4'b0010, 16'h000C},
              {4'b0001, 16'h0000}, {4'b0001, 16'h0000}, {4'b0001, 16'h0000}};
        run2("fill", s);
        n_checks++;
        if (count2 !== 2'd0 || valid2 !== 1'b0) begin
            n_fail++; $display("FAIL fill_end: count %0d valid %b, want 0 0", count2, valid2);
        end
    endtask

    task automatic test_flush();
        logic [W+3:0] s[$];
        s = '{{4'b0010, 16'h0011}, {4'b0010, 16'h0022}, {4'b1010, 16'h0077},
              {4'b0000, 16'h0000}, {4'b0010, 16'h0033}, {4'b0001, 16'h0000}};
        run2("flush", s);
    endtask

    task automatic test_halt();
        logic [W+3:0] s[$];
        s = '{{4'b0010, 16'h00D1}, {4'b0111, 16'h00D2}, {4'b0111, 16'h00D3},
              {4'b0111, 16'h00D4}, {4'b0001, 16'h0000}, {4'b0001, 16'h0000}};
        run2("halt", s);
    endtask

    task automatic test_reset_traffic();
        logic [W+3:0] s[$];
        s = '{{4'b0010, 16'h0031}};
        run2("rsttr_a", s);
        @(negedge clk);
        rst = 1'b1; v2 = 1'b1; d2 = 16'h0032;
        @(posedge clk);
        commit2(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0; v2 = 1'b0; d2 = '0;
        #1;
        n_checks++;
        if (count2 !== 2'd0 || valid2 !== 1'b0 || dout2 !== '0) begin
            n_fail++;
            $display("FAIL rsttr_cleared: count %0d valid %b data %h, want 0 0 0",
                     count2, valid2, dout2);
        end
    endtask

    task automatic test_back_to_back();
        logic ev, ea;
        logic [W-1:0] ed;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            v3 = (c < 10);
            a3 = 1'b1;
            d3 = (c < 10) ? W'(16'h0100 + c) : '0;
            #1;
            ea = m_ack(sb3.size(), 3);
            ev = m_valid(sb3.size(), v3);
            ed = (sb3.size() != 0) ? sb3[0] : d3;
            n_checks++;
            if (ack3 !== ea || valid3 !== ev) begin
                n_fail++;
                $display("FAIL b2b_hs cyc %0d: ack %b valid %b, want %b %b", c, ack3, valid3, ea, ev);
            end
            n_checks++;
            if (count3 !== 2'(sb3.size())) begin
                n_fail++;
                $display("FAIL b2b_count cyc %0d: got %0d, want %0d", c, count3, sb3.size());
            end
            if (ev) begin
                n_checks++;
                if (dout3 !== ed) begin
                    n_fail++; $display("FAIL b2b_data cyc %0d: got %h, want %h", c, dout3, ed);
                end
            end
            @(posedge clk);
            commit3(ev, ea);
        end
        @(negedge clk);
        v3 = 1'b0; a3 = 1'b0;
    endtask

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
    task automatic test_bypass();
        @(negedge clk);
        v2 = 1'b1; d2 = 16'h0055; a2 = 1'b1;
        #1;
        n_checks++;
        if (valid2 !== 1'b1 || dout2 !== 16'h0055 || count2 !== 2'd0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: valid %b data %h count %0d, want 1 0055 0",
                     valid2, dout2, count2);
        end
        @(negedge clk);
        v2 = 1'b0; a2 = 1'b0; d2 = '0;
        #1;
        n_checks++;
        if (count2 !== 2'd0 || valid2 !== 1'b0) begin
            n_fail++; $display("FAIL bypass_after: count %0d valid %b, want 0 0", count2, valid2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_halt();
        test_reset_traffic();
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
